// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues aligned 8-byte I-cache requests under FIFO credit
// control, tracks in-flight requests and discards stale responses after a redirect.
// Optional build macro FETCH_PERF_COUNTER_EN adds stall / dropped-word performance counters.
module fetch_controller #(
  parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [3:0]  fifo_count,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [63:0] icache_resp_data,
  output logic        fifo_write_en1,
  output logic        fifo_write_en2,
  output logic [31:0] fifo_write_data1,
  output logic [31:0] fifo_write_data2,
  output logic [31:0] fifo_write_address1,
  output logic [31:0] fifo_write_address2,
  output logic [31:0] fetch_pc
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_dropped_words
`endif
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  state_t          state;
  logic [31:0]     pc_q;
  logic [1:0]      outstanding;
  logic [1:0]      drop_count;
  logic            active;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     tag_pc [MAX_OUTSTANDING];

  logic            live;
  logic            credit_ok;
  logic            room;
  logic            req_valid;
  logic            accept;
  logic            resp_hit;
  logic            write;
  logic            one_word;
  logic [31:0]     head_pc;
  logic [5:0]      credit_need;
  logic [1:0]      out_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outputs stay quiet while in reset and for the first cycle after it.
  assign live        = active & ~rst;
  assign credit_need = {2'b00, fifo_count} + {3'b000, outstanding, 1'b0} + 6'd2;
  assign credit_ok   = (credit_need <= 6'd14);
  assign room        = (32'(outstanding) < MAX_OUTSTANDING);
  // A request already offered in a redirect cycle may still be accepted; it is then
  // counted as in flight and its response discarded with the rest.
  assign req_valid   = live & (state == RUN) & room & credit_ok;
  assign accept      = req_valid & icache_req_ready;
  assign resp_hit    = live & icache_resp_valid & (outstanding != 2'd0);
  assign write       = resp_hit & (drop_count == 2'd0) & ~redirect_valid;
  assign head_pc     = tag_pc[rd_ptr];
  assign one_word    = head_pc[2];
  assign out_next    = outstanding + 2'(accept) - 2'(resp_hit);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    icache_req_valid    = req_valid;
    icache_req_addr     = '0;
    fetch_pc            = '0;
    fifo_write_en1      = write;
    fifo_write_en2      = write & ~one_word;
    fifo_write_data1    = '0;
    fifo_write_data2    = '0;
    fifo_write_address1 = '0;
    fifo_write_address2 = '0;
    if (live) begin
      icache_req_addr = {pc_q[31:3], 3'b000};
      fetch_pc        = pc_q;
    end
    if (write) begin
      fifo_write_address1 = head_pc;
      if (one_word) begin
        fifo_write_data1 = icache_resp_data[63:32];
      end else begin
        fifo_write_data1    = icache_resp_data[31:0];
        fifo_write_data2    = icache_resp_data[63:32];
        fifo_write_address2 = head_pc + 32'd4;
      end
    end
  end

  // NOTE: tag storage needs no reset; validity is tracked by the outstanding count alone.
  always_ff @(posedge clk) begin
    if (accept) tag_pc[wr_ptr] <= pc_q;
  end

  // NOTE: all registered state uses non-blocking assignments so every update sees
  // the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      active      <= 1'b0;
    end else begin
      active      <= 1'b1;
      outstanding <= out_next;
      if (accept)   wr_ptr <= ptr_inc(wr_ptr);
      if (resp_hit) rd_ptr <= ptr_inc(rd_ptr);
      if (redirect_valid) pc_q <= redirect_pc;
      else if (accept)    pc_q <= {pc_q[31:3] + 29'd1, 3'b000};
      case (state)
        RUN: begin
          if (redirect_valid && out_next != 2'd0) begin
            state      <= DRAIN;
            drop_count <= out_next;
          end
        end
        DRAIN: begin
          // A redirect here leaves drop_count alone: it already covers everything in flight.
          if (resp_hit) begin
            drop_count <= drop_count - 2'd1;
            if (drop_count == 2'd1) state <= RUN;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  logic [32:0] dropped_sum;
  assign dropped_sum = {1'b0, perf_dropped_words} + (one_word ? 33'd1 : 33'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles  <= '0;
      perf_dropped_words <= '0;
    end else begin
      if (live && state == RUN && !credit_ok && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (resp_hit && drop_count != 2'd0)
        perf_dropped_words <= dropped_sum[32] ? 32'hFFFF_FFFF : dropped_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random traffic,
// checked every cycle against an in-flight tag list reference model.
module tb_fetch_controller;

  localparam int MAXO = 2;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  fifo_count;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [63:0] icache_resp_data;
  logic        fifo_write_en1, fifo_write_en2;
  logic [31:0] fifo_write_data1, fifo_write_data2;
  logic [31:0] fifo_write_address1, fifo_write_address2;
  logic [31:0] fetch_pc;

  fetch_controller #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .fifo_count          (fifo_count),
    .icache_req_valid    (icache_req_valid),
    .icache_req_ready    (icache_req_ready),
    .icache_req_addr     (icache_req_addr),
    .icache_resp_valid   (icache_resp_valid),
    .icache_resp_data    (icache_resp_data),
    .fifo_write_en1      (fifo_write_en1),
    .fifo_write_en2      (fifo_write_en2),
    .fifo_write_data1    (fifo_write_data1),
    .fifo_write_data2    (fifo_write_data2),
    .fifo_write_address1 (fifo_write_address1),
    .fifo_write_address2 (fifo_write_address2),
    .fetch_pc            (fetch_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the fake I-cache.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  // Reference model: fetch pc, plus the list of requests in flight; a request
  // alive at a redirect is marked doomed and its response must never reach the FIFO.
  typedef struct {
    logic [31:0] pc;
    bit          doomed;
  } tag_t;

  tag_t        tagq[$];
  logic [31:0] cache_q[$];
  logic [31:0] m_pc = RST_PC;
  bit          m_active = 1'b0;

  // Snapshot of the last checked cycle, used by directed checks.
  logic        s_valid, s_en1, s_en2;
  logic [31:0] s_addr, s_a1, s_d1;

  task automatic cycle(input bit r, input bit redir, input logic [31:0] rpc,
                       input int fc, input bit rdy, input bit rv);
    bit          live, draining, exp_valid, resp_pop, wr, two, acc_dut;
    logic [31:0] hpc;
    @(negedge clk);
    rst              = r;
    redirect_valid   = redir;
    redirect_pc      = rpc;
    fifo_count       = 4'(fc);
    icache_req_ready = rdy;
    if (r) begin
      icache_resp_valid = rv;
      icache_resp_data  = {$urandom, $urandom};
    end else if (rv && cache_q.size() > 0) begin
      icache_resp_valid = 1'b1;
      icache_resp_data  = {word_at(cache_q[0] + 32'd4), word_at(cache_q[0])};
    end else begin
      icache_resp_valid = 1'b0;
      icache_resp_data  = {$urandom, $urandom};
    end
    #1;
    live     = m_active && !r;
    draining = 1'b0;
    foreach (tagq[i]) if (tagq[i].doomed) draining = 1'b1;
    exp_valid = live && !draining && tagq.size() < MAXO && (fc + 2 * (tagq.size() + 1) <= 14);
    resp_pop  = live && icache_resp_valid && tagq.size() > 0;
    hpc       = (tagq.size() > 0) ? tagq[0].pc : 32'd0;
    wr        = resp_pop && !tagq[0].doomed && !redir;
    two       = (hpc[2] == 1'b0);

    s_valid = icache_req_valid; s_addr = icache_req_addr; s_en1 = fifo_write_en1;
    s_en2 = fifo_write_en2; s_a1 = fifo_write_address1; s_d1 = fifo_write_data1;

    check("req_valid", 64'(icache_req_valid), 64'(exp_valid));
    check("en1", 64'(fifo_write_en1), 64'(wr));
    check("en2", 64'(fifo_write_en2), 64'(wr && two));
    if (!live) begin
      check("rst_req_addr", 64'(icache_req_addr), 64'd0);
      check("rst_data1", 64'(fifo_write_data1), 64'd0);
      check("rst_addr1", 64'(fifo_write_address1), 64'd0);
      check("rst_data2", 64'(fifo_write_data2), 64'd0);
      check("rst_addr2", 64'(fifo_write_address2), 64'd0);
    end else begin
      check("fetch_pc", 64'(fetch_pc), 64'(m_pc));
      if (exp_valid) check("req_addr", 64'(icache_req_addr), 64'({m_pc[31:3], 3'b000}));
      if (wr) begin
        check("addr1", 64'(fifo_write_address1), 64'(hpc));
        check("data1", 64'(fifo_write_data1), 64'(word_at(hpc)));
        if (two) begin
          check("addr2", 64'(fifo_write_address2), 64'(hpc + 32'd4));
          check("data2", 64'(fifo_write_data2), 64'(word_at(hpc + 32'd4)));
        end
      end
    end

    acc_dut = !r && icache_req_valid && rdy;
    if (r) begin
      tagq.delete();
      cache_q.delete();
      m_active = 1'b0;
      m_pc     = RST_PC;
    end else begin
      m_active = 1'b1;
      if (icache_resp_valid) void'(cache_q.pop_front());
      if (acc_dut) cache_q.push_back(icache_req_addr);
      if (resp_pop) void'(tagq.pop_front());
      if (exp_valid && rdy) begin
        tagq.push_back('{pc: m_pc, doomed: 1'b0});
        m_pc = {m_pc[31:3], 3'b000} + 32'd8;
      end
      if (redir) begin
        foreach (tagq[i]) tagq[i].doomed = 1'b1;
        m_pc = rpc;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; fifo_count = '0;
    icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = '0;

    // Reset with garbage responses, then first cycle after reset stays quiet.
    for (int i = 0; i < 3; i++) cycle(1, 0, 32'd0, 0, 1, 1);
    cycle(0, 0, 32'd0, 0, 1, 1);
    check("first_cycle_valid", 64'(s_valid), 64'd0);

    // First request at the reset vector, then a two-word write.
    cycle(0, 0, 32'd0, 0, 1, 0);
    check("reset_vec_req", 64'(s_addr), 64'hBFC0_0000);
    cycle(0, 0, 32'd0, 0, 0, 1);
    check("reset_vec_en", 64'({s_en1, s_en2}), 64'd3);
    check("reset_vec_a1", 64'(s_a1), 64'hBFC0_0000);

    // Redirect to an odd word with nothing in flight: single-word write.
    cycle(0, 1, 32'h8000_0004, 0, 0, 0);
    cycle(0, 0, 32'd0, 0, 1, 0);
    check("redir_req", 64'(s_addr), 64'h8000_0000);
    cycle(0, 0, 32'd0, 0, 0, 1);
    check("one_word_en", 64'({s_en1, s_en2}), 64'd2);
    check("one_word_a1", 64'(s_a1), 64'h8000_0004);
    check("one_word_d1", 64'(s_d1), 64'(word_at(32'h8000_0004)));
    cycle(0, 0, 32'd0, 0, 1, 0);
    check("after_one_word_req", 64'(s_addr), 64'h8000_0008);
    cycle(0, 0, 32'd0, 0, 0, 1);

    // Two in flight, redirect: both dropped, then fetch resumes at the target.
    cycle(0, 0, 32'd0, 0, 1, 0);
    cycle(0, 0, 32'd0, 0, 1, 0);
    cycle(0, 1, 32'h0000_0100, 0, 0, 0);
    cycle(0, 0, 32'd0, 0, 1, 1);
    check("drain_drop1", 64'(s_en1), 64'd0);
    check("drain_novalid", 64'(s_valid), 64'd0);
    cycle(0, 0, 32'd0, 0, 1, 1);
    check("drain_drop2", 64'(s_en1), 64'd0);
    cycle(0, 0, 32'd0, 0, 1, 0);
    check("post_drain_req", 64'(s_addr), 64'h0000_0100);
    check("post_drain_valid", 64'(s_valid), 64'd1);
    cycle(0, 0, 32'd0, 0, 0, 1);

    // Credit boundary with one outstanding.
    cycle(0, 0, 32'd0, 0, 1, 0);
    cycle(0, 0, 32'd0, 10, 0, 0);
    check("credit_10", 64'(s_valid), 64'd1);
    cycle(0, 0, 32'd0, 11, 0, 0);
    check("credit_11", 64'(s_valid), 64'd0);
    cycle(0, 0, 32'd0, 11, 0, 1);
    cycle(0, 0, 32'd0, 11, 0, 0);
    check("credit_11_empty", 64'(s_valid), 64'd1);

    // Redirect together with a response and an accepted request.
    cycle(0, 0, 32'd0, 0, 1, 0);
    cycle(0, 1, 32'h0000_2000, 0, 1, 1);
    check("redir_same_cycle_en", 64'(s_en1), 64'd0);
    check("redir_same_cycle_acc", 64'(s_valid), 64'd1);
    cycle(0, 0, 32'd0, 0, 1, 1);
    check("redir_next_drop", 64'(s_en1), 64'd0);
    cycle(0, 0, 32'd0, 0, 1, 0);
    check("redir_resume", 64'(s_addr), 64'h0000_2000);
    cycle(0, 0, 32'd0, 0, 0, 1);

    // Reset with two in flight; responses during reset are ignored.
    cycle(0, 0, 32'd0, 0, 1, 0);
    cycle(0, 0, 32'd0, 0, 1, 0);
    cycle(1, 0, 32'd0, 0, 1, 1);
    check("rst_inflight_en", 64'(s_en1), 64'd0);
    cycle(1, 0, 32'd0, 0, 1, 1);
    cycle(0, 0, 32'd0, 0, 1, 1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, rd;
      r  = ($urandom_range(0, 599) == 0);
      rd = ($urandom_range(0, 15) == 0);
      cycle(r, rd, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 14),
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
